// File: rtl/srio_ireq_rr_mux.sv
// Packet-atomic round-robin mux of NUM_CH AXI-Stream request sources onto the SRIO ireq port,
// with link gating, per-channel packet counters and sticky stall / over-length flags.
module srio_ireq_rr_mux #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int USER_W    = 32,
    parameter int MAX_BEATS = 33,
    parameter int STALL_MAX = 1024,
    parameter int CNT_W     = 16,
    localparam int KEEP_W   = DATA_W / 8,
    localparam int GID_W    = $clog2(NUM_CH)
) (
    input  logic                       log_clk,
    input  logic                       sys_rst,
    input  logic                       link_initialized,
    input  logic [NUM_CH-1:0]          s_ireq_tvalid,
    output logic [NUM_CH-1:0]          s_ireq_tready,
    input  logic [NUM_CH-1:0]          s_ireq_tlast,
    input  logic [NUM_CH*DATA_W-1:0]   s_ireq_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]   s_ireq_tkeep,
    input  logic [NUM_CH*USER_W-1:0]   s_ireq_tuser,
    output logic                       m_ireq_tvalid,
    input  logic                       m_ireq_tready,
    output logic                       m_ireq_tlast,
    output logic [DATA_W-1:0]          m_ireq_tdata,
    output logic [KEEP_W-1:0]          m_ireq_tkeep,
    output logic [USER_W-1:0]          m_ireq_tuser,
    input  logic                       err_clr,
    output logic [NUM_CH-1:0]          err_stall,
    output logic [NUM_CH-1:0]          err_len,
    output logic [NUM_CH*CNT_W-1:0]    pkt_cnt,
    output logic                       busy,
    output logic [GID_W-1:0]           grant_id
);

    localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [GID_W-1:0]    grant_reg, last_grant_reg;
    logic [GID_W-1:0]    arb_sel, arb_idx;
    logic                arb_found;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [STALL_W-1:0]  stall_cnt_reg;
    logic [NUM_CH-1:0]   err_stall_reg, err_len_reg;
    logic [NUM_CH-1:0]   stall_set, len_set;
    logic                g_valid, acc, acc_last, grant_go;

    assign g_valid  = s_ireq_tvalid[grant_reg];
    assign acc      = (state_reg == BUSY) && g_valid && m_ireq_tready;
    assign acc_last = acc && s_ireq_tlast[grant_reg];
    assign grant_go = (state_reg == IDLE) && link_initialized && arb_found;

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            arb_idx = GID_W'((int'(last_grant_reg) + off) % NUM_CH);
            if (s_ireq_tvalid[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    always_ff @(posedge log_clk or posedge sys_rst) begin
        if (sys_rst) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_go) state_next = BUSY;
            BUSY:    if (acc_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_ireq_tvalid = 1'b0;
        m_ireq_tlast  = 1'b0;
        m_ireq_tdata  = '0;
        m_ireq_tkeep  = '0;
        m_ireq_tuser  = '0;
        s_ireq_tready = '0;
        if (state_reg == BUSY) begin
            m_ireq_tvalid            = g_valid;
            m_ireq_tlast             = s_ireq_tlast[grant_reg];
            m_ireq_tdata             = s_ireq_tdata[int'(grant_reg)*DATA_W +: DATA_W];
            m_ireq_tkeep             = s_ireq_tkeep[int'(grant_reg)*KEEP_W +: KEEP_W];
            m_ireq_tuser             = s_ireq_tuser[int'(grant_reg)*USER_W +: USER_W];
            s_ireq_tready[grant_reg] = m_ireq_tready;
        end
    end

    assign busy = (state_reg == BUSY);

    // The over-length beat is still forwarded; only the flag records it.
    always_comb begin
        stall_set = '0;
        len_set   = '0;
        if ((state_reg == BUSY) && !g_valid && (stall_cnt_reg == STALL_W'(STALL_MAX - 1)))
            stall_set[grant_reg] = 1'b1;
        if (acc && (beat_cnt_reg == BEAT_W'(MAX_BEATS)))
            len_set[grant_reg] = 1'b1;
    end

    always_ff @(posedge log_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_reg      <= '0;
            last_grant_reg <= GID_W'(NUM_CH - 1);
            beat_cnt_reg   <= '0;
            stall_cnt_reg  <= '0;
            err_stall_reg  <= '0;
            err_len_reg    <= '0;
        end else begin
            if (grant_go) begin
                grant_reg     <= arb_sel;
                beat_cnt_reg  <= '0;
                stall_cnt_reg <= '0;
            end else if (state_reg == BUSY) begin
                if (acc) begin
                    stall_cnt_reg <= '0;
                    if (beat_cnt_reg != BEAT_W'(MAX_BEATS))
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                end else if (!g_valid && (stall_cnt_reg != STALL_W'(STALL_MAX))) begin
                    stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
                end
                if (acc_last)
                    last_grant_reg <= grant_reg;
            end
            err_stall_reg <= (err_stall_reg & ~{NUM_CH{err_clr}}) | stall_set;
            err_len_reg   <= (err_len_reg & ~{NUM_CH{err_clr}}) | len_set;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] pkt_cnt_reg;
            always_ff @(posedge log_clk or posedge sys_rst) begin
                if (sys_rst)
                    pkt_cnt_reg <= '0;
                else if (acc_last && (grant_reg == GID_W'(gi)))
                    pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
            end
            assign pkt_cnt[gi*CNT_W +: CNT_W] = pkt_cnt_reg;
        end
    endgenerate

    assign err_stall = err_stall_reg;
    assign err_len   = err_len_reg;
    assign grant_id  = grant_reg;

endmodule
